dcm_clkgen_prog: RTL and testbench

Sequencer that programs a Spartan-6 DCM_CLKGEN's M/D ratio at runtime over its serial PROG port (PROGEN/PROGDATA/PROGDONE). It sits between the register block on the register clock and the clock-generation DCM. It loads latched D-1 and M-1 values, issues GO, and reports completion, timeout or a bad-argument error back to the register file. PROGCLK of the DCM is driven from the same `clk`.

---
 rtl/dcm_clkgen_prog.sv | 202 ++++++++++++++++++++
 tb/tb_dcm_clkgen_prog.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dcm_clkgen_prog.sv
// dcm_clkgen_prog: drives the Spartan-6 DCM_CLKGEN PROG port (PROGEN/PROGDATA)
// to load D-1 and M-1, issue GO and wait for PROGDONE, reporting done/error to
// the register file. All outputs are registered and aligned with the state.
// Optional feature: define DCM_PROG_LOCK_WAIT_EN to also wait for LOCKED after
// PROGDONE before reporting success.
module dcm_clkgen_prog #(
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] mult_i,
    input  logic [7:0] div_i,
    output logic       prog_en_o,
    output logic       prog_data_o,
    input  logic       prog_done_i,
    input  logic       locked_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       timeout_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOADD,
        S_GAP_D,
        S_LOADM,
        S_GAP_M,
        S_GO,
        S_WAIT_DONE,
`ifdef DCM_PROG_LOCK_WAIT_EN
        S_WAIT_LOCK,
`endif
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  mult_q, div_q;
    logic        latch;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    // Holds FINISH one extra cycle on the bad-argument path so done lands two
    // cycles after the accepted start.
    logic        hold_q, hold_d;

    logic        en_d, data_d, busy_d, done_d;
    logic [3:0]  idx;

`ifndef DCM_PROG_LOCK_WAIT_EN
    logic unused_locked;
    assign unused_locked = locked_i;
`endif

    // State, counters, latched arguments and registered outputs
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            bit_q       <= 4'd0;
            wait_q      <= 16'd0;
            mult_q      <= 8'd0;
            div_q       <= 8'd0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            hold_q      <= 1'b0;
            prog_en_o   <= 1'b0;
            prog_data_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            prog_en_o   <= en_d;
            prog_data_o <= data_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            if (latch) begin
                mult_q <= mult_i;
                div_q  <= div_i;
            end
        end
    end

    assign err_o     = err_q;
    assign timeout_o = tmo_q;

    // Next-state, counter and sticky-flag logic
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        latch   = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    latch = 1'b1;
                    err_d = 1'b0;
                    tmo_d = 1'b0;
                    bit_d = 4'd0;
                    if (mult_i == 8'd0) begin
                        state_d = S_FINISH;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = S_LOADD;
                    end
                end
            end
            S_LOADD: begin
                if (bit_q == 4'd9) begin
                    state_d = S_GAP_D;
                    bit_d   = 4'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_GAP_D: state_d = S_LOADM;
            S_LOADM: begin
                if (bit_q == 4'd9) begin
                    state_d = S_GAP_M;
                    bit_d   = 4'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_GAP_M: state_d = S_GO;
            S_GO: begin
                state_d = S_WAIT_DONE;
                wait_d  = 16'd0;
            end
            S_WAIT_DONE: begin
                // PROGDONE takes priority over a same-cycle timeout.
                if (prog_done_i) begin
`ifdef DCM_PROG_LOCK_WAIT_EN
                    state_d = S_WAIT_LOCK;
                    wait_d  = 16'd0;
`else
                    state_d = S_FINISH;
`endif
                end else if (wait_q == TIMEOUT) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
`ifdef DCM_PROG_LOCK_WAIT_EN
            S_WAIT_LOCK: begin
                if (locked_i) begin
                    state_d = S_FINISH;
                end else if (wait_q == TIMEOUT) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
`endif
            S_FINISH: begin
                if (hold_q) hold_d = 1'b0;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with it
    always_comb begin
        en_d   = 1'b0;
        data_d = 1'b0;
        idx    = bit_d - 4'd2;
        case (state_d)
            S_LOADD: begin
                en_d = 1'b1;
                if (bit_d == 4'd0)      data_d = 1'b1;
                else if (bit_d == 4'd1) data_d = 1'b0;
                else                    data_d = div_q[idx[2:0]];
            end
            S_LOADM: begin
                en_d = 1'b1;
                if (bit_d <= 4'd1) data_d = 1'b1;
                else               data_d = mult_q[idx[2:0]];
            end
            S_GO:    en_d = 1'b1;
            default: en_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH) && !hold_d;
    end

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Directed bench for dcm_clkgen_prog (TIMEOUT=20). Cycle numbering: the start
// is sampled at edge N; "cycle N+c" is the interval after edge N+c-1, sampled
// 1ns after that edge.
module tb_dcm_clkgen_prog;
    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [7:0] mult_i, div_i;
    logic       prog_en_o, prog_data_o;
    logic       prog_done_i, locked_i;
    logic       busy_o, done_o, err_o, timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    dcm_clkgen_prog #(.TIMEOUT(16'd20)) dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i),
        .mult_i(mult_i), .div_i(div_i),
        .prog_en_o(prog_en_o), .prog_data_o(prog_data_o),
        .prog_done_i(prog_done_i), .locked_i(locked_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected PROGEN/PROGDATA in cycle N+c, c = 1..23
    function automatic logic exp_en(input int c);
        return (c <= 10) || (c >= 12 && c <= 21) || (c == 23);
    endfunction

    function automatic logic exp_data(input int c, input logic [7:0] m, input logic [7:0] d);
        if (c == 1) return 1'b1;
        if (c == 2) return 1'b0;
        if (c >= 3 && c <= 10) return d[c-3];
        if (c == 12 || c == 13) return 1'b1;
        if (c >= 14 && c <= 21) return m[c-14];
        return 1'b0;
    endfunction

    // Issue a start at edge N; returns in cycle N+1
    task automatic do_start(input logic [7:0] m, input logic [7:0] d);
        mult_i  = m;
        div_i   = d;
        start_i = 1'b1;
        step;
        start_i = 1'b0;
    endtask

    // Check cycles N+1..N+23; optionally disturb mult_i at N+3 and re-pulse
    // start_i at N+5. Returns in cycle N+24.
    task automatic check_shift(input logic [7:0] m, input logic [7:0] d, input bit disturb);
        for (int c = 1; c <= 23; c++) begin
            chk($sformatf("en[N+%0d]", c), {15'd0, prog_en_o}, {15'd0, exp_en(c)});
            chk($sformatf("data[N+%0d]", c), {15'd0, prog_data_o}, {15'd0, exp_data(c, m, d)});
            chk($sformatf("busy[N+%0d]", c), {15'd0, busy_o}, 16'd1);
            if (disturb && c == 3) mult_i = ~m;
            if (disturb && c == 5) start_i = 1'b1;
            step;
            start_i = 1'b0;
        end
    endtask

    // From cycle N+24, raise prog_done_i so it is sampled at edge N+k;
    // expects done in N+k+1 (plus one cycle of lock wait when enabled).
    task automatic finish_ok(input int k);
        for (int c = 24; c < k; c++) begin
            chk("wait_en", {15'd0, prog_en_o}, 16'd0);
            chk("wait_done", {15'd0, done_o}, 16'd0);
            step;
        end
        prog_done_i = 1'b1;
        step;
        prog_done_i = 1'b0;
`ifdef DCM_PROG_LOCK_WAIT_EN
        chk("lock_done_early", {15'd0, done_o}, 16'd0);
        step;
`endif
        chk("ok_done", {15'd0, done_o}, 16'd1);
        chk("ok_busy", {15'd0, busy_o}, 16'd1);
        chk("ok_err", {14'd0, err_o, timeout_o}, 16'd0);
        step;
        chk("ok_done_clr", {15'd0, done_o}, 16'd0);
        chk("ok_busy_clr", {15'd0, busy_o}, 16'd0);
    endtask

    initial begin
        reset_i     = 1'b0;
        start_i     = 1'b0;
        mult_i      = 8'd0;
        div_i       = 8'd0;
        prog_done_i = 1'b0;
        locked_i    = 1'b1;
        step; step;
        chk("reset_outs", {10'd0, prog_en_o, prog_data_o, busy_o, done_o, err_o, timeout_o}, 16'd0);
        reset_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step;
            chk("idle_outs", {10'd0, prog_en_o, prog_data_o, busy_o, done_o, err_o, timeout_o}, 16'd0);
        end

        // Basic program M-1=4, D-1=1, PROGDONE sampled at N+30
        do_start(8'h04, 8'h01);
        check_shift(8'h04, 8'h01, 1'b0);
        finish_ok(30);

        // Bad argument: done at N+2, no PROG activity
        do_start(8'h00, 8'h05);
        chk("bad_n1_busy", {15'd0, busy_o}, 16'd1);
        chk("bad_n1_err", {15'd0, err_o}, 16'd1);
        chk("bad_n1_done", {15'd0, done_o}, 16'd0);
        chk("bad_n1_en", {15'd0, prog_en_o}, 16'd0);
        step;
        chk("bad_n2_done", {15'd0, done_o}, 16'd1);
        chk("bad_n2_flags", {14'd0, err_o, timeout_o}, 16'b10);
        chk("bad_n2_en", {15'd0, prog_en_o}, 16'd0);
        step;
        chk("bad_n3_done", {15'd0, done_o}, 16'd0);
        chk("bad_n3_busy", {15'd0, busy_o}, 16'd0);
        chk("bad_n3_err_sticky", {15'd0, err_o}, 16'd1);
        chk("bad_n3_en", {15'd0, prog_en_o}, 16'd0);
        step;

        // Next valid start clears the error
        do_start(8'h02, 8'h00);
        chk("clr_err", {15'd0, err_o}, 16'd0);
        check_shift(8'h02, 8'h00, 1'b0);
        finish_ok(26);

        // Timeout: WAIT_DONE spans N+24..N+44 (counter 0..20), done at N+45
        do_start(8'h10, 8'h03);
        check_shift(8'h10, 8'h03, 1'b0);
        for (int c = 24; c <= 44; c++) begin
            chk("tmo_wait_done", {15'd0, done_o}, 16'd0);
            chk("tmo_wait_busy", {15'd0, busy_o}, 16'd1);
            step;
        end
        chk("tmo_done", {15'd0, done_o}, 16'd1);
        chk("tmo_flags", {14'd0, err_o, timeout_o}, 16'b11);
        step;
        chk("tmo_done_clr", {15'd0, done_o}, 16'd0);
        chk("tmo_busy_clr", {15'd0, busy_o}, 16'd0);
        chk("tmo_sticky", {14'd0, err_o, timeout_o}, 16'b11);
        step;

        // Restart and mult_i change while busy are ignored
        do_start(8'hA5, 8'h3C);
        chk("ign_clr_flags", {14'd0, err_o, timeout_o}, 16'd0);
        check_shift(8'hA5, 8'h3C, 1'b1);
        finish_ok(27);
        for (int i = 0; i < 5; i++) begin
            chk("ign_no_requeue", {14'd0, prog_en_o, busy_o}, 16'd0);
            step;
        end

        // Asynchronous reset mid-sequence at N+15, then a full reissue
        do_start(8'h81, 8'h7E);
        for (int c = 1; c < 15; c++) step;
        chk("rst_pre_en", {15'd0, prog_en_o}, 16'd1);
        reset_i = 1'b0;
        #1;
        chk("rst_async", {12'd0, prog_en_o, prog_data_o, busy_o, done_o}, 16'd0);
        step;
        reset_i = 1'b1;
        step;
        do_start(8'h81, 8'h7E);
        check_shift(8'h81, 8'h7E, 1'b0);
        finish_ok(28);

`ifdef DCM_PROG_LOCK_WAIT_EN
        // Lock arrives 10 cycles after PROGDONE: sampled at N+40, done at N+41
        locked_i = 1'b0;
        do_start(8'h04, 8'h01);
        check_shift(8'h04, 8'h01, 1'b0);
        for (int c = 24; c <= 40; c++) begin
            if (c == 30) prog_done_i = 1'b1;
            if (c == 31) prog_done_i = 1'b0;
            if (c == 40) locked_i = 1'b1;
            chk("lk_wait_done", {15'd0, done_o}, 16'd0);
            step;
        end
        chk("lk_done", {15'd0, done_o}, 16'd1);
        chk("lk_flags", {14'd0, err_o, timeout_o}, 16'd0);
        step;
        chk("lk_busy_clr", {15'd0, busy_o}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
